// File: rtl/par_sng_lanes.sv
// Parallel deterministic stochastic number generator: emits a 2^WIDTH-bit unipolar
// stream holding exactly `value` ones, LANES bits per beat, in unary or van der Corput order.
`timescale 1ns/1ps
module par_sng_lanes #(
  parameter int WIDTH = 8,
  parameter int LANES = 8,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value,
  output logic [LANES-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int BEATS = (1 << WIDTH) / LANES;
  localparam int CW    = $clog2(BEATS);
  localparam int CNT_W = (CW > 0) ? CW : 1;
  localparam int LB    = $clog2(LANES);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   v_q, v_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load;
  logic [WIDTH-1:0]   base_w;

  assign out_valid = (state_q == STREAM);
  assign busy      = out_valid;
  // With a single beat per stream the counter stays at 0, so this is always true.
  assign out_last  = out_valid && (cnt_q == CNT_W'(BEATS - 1));
  assign in_ready  = (state_q == IDLE) || (out_valid && out_ready && out_last);
  assign load      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    if (out_valid && out_ready) begin
      cnt_d = out_last ? '0 : cnt_q + 1'b1;
      if (out_last) begin
        state_d = IDLE;
      end
    end
    if (load) begin
      v_d     = value;
      cnt_d   = '0;
      state_d = STREAM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
    end
  end

  // Global bit index of lane j is cnt*LANES + j; LANES is a power of two.
  assign base_w = WIDTH'(cnt_q) << LB;

  genvar gi, gb;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH-1:0] k_w;
      logic [WIDTH-1:0] rev_w;
      logic [WIDTH-1:0] idx_w;

      assign k_w = base_w | WIDTH'(gi);

      for (gb = 0; gb < WIDTH; gb++) begin : g_rev
        assign rev_w[gb] = k_w[WIDTH-1-gb];
      end

      assign idx_w        = (MODE == 1) ? rev_w : k_w;
      assign data_out[gi] = out_valid && (idx_w < v_q);
    end
  endgenerate

endmodule

// File: tb/tb_par_sng_lanes.sv
// Bench for par_sng_lanes: hand-computed 4-bit beat tables on unary and bit-reversed
// instances, plus an 8-bit sweep whose per-stream ones-count must equal the value.
`timescale 1ns/1ps
module tb_par_sng_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [3:0] a_value, a_data;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [3:0] b_value, b_data;
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_busy;
  logic       d_in_ready, d_out_valid, d_out_last, d_busy;
  logic [7:0] c_value, c_data, d_data;

  par_sng_lanes #(.WIDTH(4), .LANES(4), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .value(a_value),
    .data_out(a_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_last(a_out_last), .busy(a_busy));
  par_sng_lanes #(.WIDTH(4), .LANES(4), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .value(b_value),
    .data_out(b_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_last(b_out_last), .busy(b_busy));
  par_sng_lanes #(.WIDTH(8), .LANES(8), .MODE(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .value(c_value),
    .data_out(c_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_last(c_out_last), .busy(c_busy));
  par_sng_lanes #(.WIDTH(8), .LANES(8), .MODE(1)) u_d (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(d_in_ready), .value(c_value),
    .data_out(d_data), .out_valid(d_out_valid), .out_ready(c_out_ready),
    .out_last(d_out_last), .busy(d_busy));

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] qa[$];
  logic [4:0] qb[$];
  int         qc[$];
  int         qd[$];
  int         acc_c = 0;
  int         acc_d = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Expected beats are {out_last, data_out}; only the fourth beat carries out_last.
  task automatic push_a(input logic [3:0] b0, b1, b2, b3);
    qa.push_back({1'b0, b0}); qa.push_back({1'b0, b1});
    qa.push_back({1'b0, b2}); qa.push_back({1'b1, b3});
  endtask

  task automatic push_b(input logic [3:0] b0, b1, b2, b3);
    qb.push_back({1'b0, b0}); qb.push_back({1'b0, b1});
    qb.push_back({1'b0, b2}); qb.push_back({1'b1, b3});
  endtask

  // Called just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send_a(input logic [3:0] v, input bit expect_b2b);
    int t = 0;
    a_value = v;
    a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!a_in_ready) fail_now("a_accept_timeout");
    if (expect_b2b) check("b2b_ready_on_last", {a_out_valid, a_out_last}, 2'b11);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    if (expect_b2b) check("b2b_no_bubble", a_out_valid, 1'b1);
  endtask

  task automatic send_b(input logic [3:0] v);
    int t = 0;
    b_value = v;
    b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!b_in_ready) fail_now("b_accept_timeout");
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int t = 0;
    @(negedge clk);
    while (a_out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (a_out_valid) fail_now("a_drain_timeout");
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("a_busy", a_busy, a_out_valid);
      if (!a_out_valid) check("a_idle_data", {a_out_last, a_data}, 5'd0);
      else if (qa.size() == 0) fail_now("a_unexpected_beat");
      else if (a_out_ready) check("a_beat", {a_out_last, a_data}, qa.pop_front());
      else check("a_stall_hold", {a_out_last, a_data}, qa[0]);
    end
  end

  always @(negedge clk) begin
    if (rst && b_out_valid) begin
      if (qb.size() == 0) fail_now("b_unexpected_beat");
      else if (b_out_ready) check("b_beat", {b_out_last, b_data}, qb.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst && c_out_valid && c_out_ready) begin
      acc_c += $countones(c_data);
      if (c_out_last) begin
        if (qc.size() == 0) fail_now("c_unexpected_stream");
        else check("c_total_unary", acc_c, qc.pop_front());
        acc_c = 0;
      end
    end
    if (rst && d_out_valid && c_out_ready) begin
      acc_d += $countones(d_data);
      if (d_out_last) begin
        if (qd.size() == 0) fail_now("d_unexpected_stream");
        else check("d_total_bitrev", acc_d, qd.pop_front());
        acc_d = 0;
      end
    end
  end

  initial begin
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int t;
    rst = 1'b0;
    a_in_valid = 1'b0; a_value = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_value = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_value = '0; c_out_ready = 1'b1;
    #2;
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_last", a_out_last, 1'b0);
    check("rst_data", a_data, 4'd0);
    check("rst_busy", a_busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Unary value 5, then bit-reversed value 5, then 15 and 0 back-to-back.
    push_a(4'b1111, 4'b0001, 4'b0000, 4'b0000);
    send_a(4'd5, 1'b0);
    push_b(4'b0101, 4'b0001, 4'b0001, 4'b0001);
    send_b(4'd5);
    push_a(4'b1111, 4'b1111, 4'b1111, 4'b0111);
    send_a(4'd15, 1'b0);
    push_a(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    send_a(4'd0, 1'b0);
    drain_a();

    // Backpressure: beat 1 must hold for three cycles.
    push_a(4'b1111, 4'b1111, 4'b0001, 4'b0000);
    send_a(4'd9, 1'b0);
    for (int i = 0; i < 6; i++) begin
      a_out_ready = pat[i];
      @(posedge clk);
      #1;
    end
    a_out_ready = 1'b1;
    drain_a();

    // Back-to-back: 3 then 12 with no idle cycle between them.
    push_a(4'b0111, 4'b0000, 4'b0000, 4'b0000);
    push_a(4'b1111, 4'b1111, 4'b1111, 4'b0000);
    send_a(4'd3, 1'b0);
    send_a(4'd12, 1'b1);
    drain_a();

    // Reset mid-stream during beat 2 aborts the stream without a clock edge.
    push_a(4'b1111, 4'b1111, 4'b0001, 4'b0000);
    send_a(4'd9, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_abort_beat2", {a_out_valid, a_data}, 5'b10001);
    rst = 1'b0;
    #1;
    check("abort_out_valid", a_out_valid, 1'b0);
    check("abort_out_last", a_out_last, 1'b0);
    check("abort_data", a_data, 4'd0);
    check("abort_in_ready", a_in_ready, 1'b1);
    qa.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_a(4'b1111, 4'b0111, 4'b0000, 4'b0000);
    send_a(4'd7, 1'b0);
    drain_a();

    // Closed-loop sweep of every 8-bit value in both orderings.
    for (int v = 0; v < 256; v++) begin
      qc.push_back(v);
      qd.push_back(v);
      c_value = 8'(v);
      c_in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!(c_in_ready && d_in_ready) && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!(c_in_ready && d_in_ready)) fail_now("sweep_accept_timeout");
      @(posedge clk);
      #1;
    end
    c_in_valid = 1'b0;
    t = 0;
    while ((qa.size() + qb.size() + qc.size() + qd.size()) != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    check("qc_drained", qc.size(), 0);
    check("qd_drained", qd.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
